// File: rtl/itrx_aib_phy_pkg.sv
// rtl/itrx_aib_phy_pkg.sv - shared constants and helpers for AIB PHY sideband logic
// Purpose: default synchroniser/filter depths and counter-width helper.
// Ports: none (package).
package itrx_aib_phy_pkg;

  localparam int DEF_NUM_FLOPS   = 2;
  localparam int DEF_FILT_CYCLES = 4;

  // Counter width able to hold 0..filt_cycles, i.e. clog2(filt_cycles+1).
  // Never returns less than 1 so a 1-cycle filter still gets a real vector.
  function automatic int cnt_width(input int filt_cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < (filt_cycles + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_bit_filt.sv
// rtl/itrx_aib_phy_bit_filt.sv - single-channel glitch filter with edge pulses
// Purpose: update dout only after FILT_CYCLES consecutive disagreeing samples
//          (or every cycle when filt_en=0) and flag the resulting edges.
// Ports: clk, rst_n (async, active-low), s (synchronised sample), filt_en,
//        dout (filtered level), rise_pls / fall_pls (registered one-cycle edges).
module itrx_aib_phy_bit_filt
  import itrx_aib_phy_pkg::*;
#(
  parameter int   FILT_CYCLES = DEF_FILT_CYCLES,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic filt_en,
  output logic dout,
  output logic rise_pls,
  output logic fall_pls
);

  localparam int            CW       = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          dout_nxt;

  // Counter tracks how many consecutive cycles s has disagreed with dout.
  // Any agreement, any update or bypass mode returns it to 0, so it is
  // bounded by CNT_LAST and cannot wrap.
  always_comb begin
    dout_nxt = dout;
    cnt_nxt  = '0;
    if (!filt_en) begin
      dout_nxt = s;
    end else if (s != dout) begin
      if (cnt == CNT_LAST) begin
        dout_nxt = s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Pulses are derived from dout_nxt so they land on the same edge that
  // dout takes its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= RST_VAL;
      cnt      <= '0;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      dout     <= dout_nxt;
      cnt      <= cnt_nxt;
      rise_pls <= dout_nxt & ~dout;
      fall_pls <= ~dout_nxt & dout;
    end
  end

endmodule

// File: rtl/itrx_aib_phy_bit_sync.sv
// rtl/itrx_aib_phy_bit_sync.sv - single-bit multi-flop synchroniser with reset value
// Purpose: bring one asynchronous bit into the clk domain.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronised output).
module itrx_aib_phy_bit_sync
  import itrx_aib_phy_pkg::*;
#(
  parameter int   NUM_FLOPS = DEF_NUM_FLOPS,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [NUM_FLOPS-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {NUM_FLOPS{RST_VAL}};
    end else begin
      chain <= {chain[NUM_FLOPS-2:0], d};
    end
  end

  assign q = chain[NUM_FLOPS-1];

endmodule

// File: rtl/itrx_aib_phy_bit_sync_filt.sv
// rtl/itrx_aib_phy_bit_sync_filt.sv - multi-channel synchroniser, glitch filter and edge detect
// Purpose: WIDTH independent quasi-static pad bits -> clk-domain debounced levels
//          with rise/fall pulses.
// Ports: clk, rst_n (async, active-low), din[WIDTH] (async), filt_en (0 = bypass filter),
//        dout[WIDTH], rise_pls[WIDTH], fall_pls[WIDTH], any_chg (OR of all pulses).
module itrx_aib_phy_bit_sync_filt
  import itrx_aib_phy_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_FLOPS   = DEF_NUM_FLOPS,
  parameter int               FILT_CYCLES = DEF_FILT_CYCLES,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             filt_en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise_pls,
  output logic [WIDTH-1:0] fall_pls,
  output logic             any_chg
);

  logic [WIDTH-1:0] s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    itrx_aib_phy_bit_sync #(
      .NUM_FLOPS (NUM_FLOPS),
      .RST_VAL   (RST_VAL[i])
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (din[i]),
      .q     (s[i])
    );

    itrx_aib_phy_bit_filt #(
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL[i])
    ) u_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (s[i]),
      .filt_en  (filt_en),
      .dout     (dout[i]),
      .rise_pls (rise_pls[i]),
      .fall_pls (fall_pls[i])
    );
  end

  // Pure OR of flop outputs, so it is cycle-aligned with the pulses.
  assign any_chg = |(rise_pls | fall_pls);

endmodule

// File: tb/tb_itrx_aib_phy_bit_sync_filt.sv
// tb/tb_itrx_aib_phy_bit_sync_filt.sv - self-checking bench for itrx_aib_phy_bit_sync_filt
module tb_itrx_aib_phy_bit_sync_filt;

  localparam int NSW  = 9;
  localparam int NI   = NSW + 1;
  localparam int MAXE = 8000;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       filt_en;
  logic [7:0] dout;
  logic [7:0] rise_pls;
  logic [7:0] fall_pls;
  logic       any_chg;

  int checks;
  int errors;

  logic [7:0] a_dout [NI];
  logic [7:0] a_rise [NI];
  logic [7:0] a_fall [NI];
  logic       a_any  [NI];

  itrx_aib_phy_bit_sync_filt #(
    .WIDTH       (8),
    .NUM_FLOPS   (2),
    .FILT_CYCLES (4),
    .RST_VAL     (8'hA5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .filt_en  (filt_en),
    .dout     (dout),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls),
    .any_chg  (any_chg)
  );

  assign a_dout[0] = dout;
  assign a_rise[0] = rise_pls;
  assign a_fall[0] = fall_pls;
  assign a_any[0]  = any_chg;

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int         NF  = 2 + (g % 3);
    localparam int         FC  = (g / 3 == 0) ? 1 : ((g / 3 == 1) ? 2 : 7);
    localparam int         W   = (g % 2 == 0) ? 8 : 1;
    localparam logic [7:0] RV8 = 8'h5A ^ 8'(g * 37);
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic         a;
    itrx_aib_phy_bit_sync_filt #(
      .WIDTH       (W),
      .NUM_FLOPS   (NF),
      .FILT_CYCLES (FC),
      .RST_VAL     (RV8[W-1:0])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din[W-1:0]),
      .filt_en  (filt_en),
      .dout     (d),
      .rise_pls (r),
      .fall_pls (f),
      .any_chg  (a)
    );
    assign a_dout[g+1] = 8'(d);
    assign a_rise[g+1] = 8'(r);
    assign a_fall[g+1] = 8'(f);
    assign a_any[g+1]  = a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each instance: s at edge j is the din value presented at edge j-NF
  // (reset value before that). dout flips at edge k when the last FC
  // edges all had filter enabled and all saw s opposite to dout; with
  // filter disabled dout simply follows s.
  logic [7:0] din_hist [MAXE+1];
  bit         fe_hist  [MAXE+1];
  int         k;
  logic [7:0] exp_dout [NI];
  logic [7:0] exp_rise [NI];
  logic [7:0] exp_fall [NI];
  bit         exp_any  [NI];

  function automatic int cfg_w(input int n);
    if (n == 0) return 8;
    return ((n - 1) % 2 == 0) ? 8 : 1;
  endfunction

  function automatic int cfg_nf(input int n);
    if (n == 0) return 2;
    return 2 + ((n - 1) % 3);
  endfunction

  function automatic int cfg_fc(input int n);
    if (n == 0) return 4;
    if ((n - 1) / 3 == 0) return 1;
    if ((n - 1) / 3 == 1) return 2;
    return 7;
  endfunction

  function automatic logic [7:0] cfg_rv(input int n);
    logic [7:0] m;
    if (n == 0) return 8'hA5;
    m = (cfg_w(n) == 8) ? 8'hFF : 8'h01;
    return (8'h5A ^ 8'((n - 1) * 37)) & m;
  endfunction

  function automatic bit s_at(input int n, input int c, input int j);
    logic [7:0] v;
    if (j - cfg_nf(n) >= 1) v = din_hist[j - cfg_nf(n)];
    else                    v = cfg_rv(n);
    return v[c];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int n = 0; n < NI; n++) begin
      exp_dout[n] = cfg_rv(n);
      exp_rise[n] = 8'h00;
      exp_fall[n] = 8'h00;
      exp_any[n]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit cur, nv, ok;
    int fc;
    if (!rst_n) return;
    if (k < MAXE) k++;
    din_hist[k] = din;
    fe_hist[k]  = filt_en;
    for (int n = 0; n < NI; n++) begin
      fc = cfg_fc(n);
      exp_rise[n] = 8'h00;
      exp_fall[n] = 8'h00;
      for (int c = 0; c < cfg_w(n); c++) begin
        cur = exp_dout[n][c];
        nv  = cur;
        if (!filt_en) begin
          nv = s_at(n, c, k);
        end else if (k - fc + 1 >= 1) begin
          ok = 1'b1;
          for (int j = k - fc + 1; j <= k; j++) begin
            if (!fe_hist[j] || (s_at(n, c, j) == cur)) ok = 1'b0;
          end
          if (ok) nv = ~cur;
        end
        exp_dout[n][c] = nv;
        exp_rise[n][c] = nv & ~cur;
        exp_fall[n][c] = cur & ~nv;
      end
      exp_any[n] = |(exp_rise[n] | exp_fall[n]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    din = 8'h00;
    filt_en = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== 8'hA5 || rise_pls !== 8'h00 || fall_pls !== 8'h00 || any_chg !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: dout=%h rise=%h fall=%h any=%b, want dout=a5 no pulses",
                 dout, rise_pls, fall_pls, any_chg);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (dout !== ((e >= 6) ? 8'h00 : 8'hA5) || fall_pls !== ((e == 6) ? 8'hA5 : 8'h00) ||
          rise_pls !== 8'h00 || any_chg !== (e == 6)) begin
        errors++;
        $display("FAIL reset_release edge %0d: dout=%h rise=%h fall=%h any=%b", e, dout, rise_pls,
                 fall_pls, any_chg);
      end
    end
  endtask

  task automatic test_filtered_rise();
    din = 8'h01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (dout !== ((e >= 6) ? 8'h01 : 8'h00) || rise_pls !== ((e == 6) ? 8'h01 : 8'h00) ||
          fall_pls !== 8'h00 || any_chg !== (e == 6)) begin
        errors++;
        $display("FAIL filtered_rise edge %0d: dout=%h rise=%h fall=%h any=%b, want dout[0] and rise at edge 6",
                 e, dout, rise_pls, fall_pls, any_chg);
      end
    end
  endtask

  task automatic test_glitch();
    bit ed, er, ef;
    for (int w = 1; w <= 4; w++) begin
      din = 8'h09;
      for (int e = 1; e <= 14; e++) begin
        tick();
        if (e == w) din = 8'h01;
        ed = (w == 4) && (e >= 6) && (e <= 9);
        er = (w == 4) && (e == 6);
        ef = (w == 4) && (e == 10);
        checks++;
        if (dout[3] !== ed || rise_pls[3] !== er || fall_pls[3] !== ef || dout[0] !== 1'b1) begin
          errors++;
          $display("FAIL glitch w=%0d edge %0d: dout=%h rise=%h fall=%h, want d3=%b r3=%b f3=%b",
                   w, e, dout, rise_pls, fall_pls, ed, er, ef);
        end
      end
    end
  endtask

  task automatic test_bypass();
    din = 8'h00;
    repeat (10) tick();
    filt_en = 1'b0;
    din = 8'hFF;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (dout !== ((e >= 3) ? 8'hFF : 8'h00) || rise_pls !== ((e == 3) ? 8'hFF : 8'h00) ||
          fall_pls !== 8'h00 || any_chg !== (e == 3)) begin
        errors++;
        $display("FAIL bypass edge %0d: dout=%h rise=%h fall=%h any=%b", e, dout, rise_pls,
                 fall_pls, any_chg);
      end
    end
    // start filtered count toward 00, then drop to bypass mid-count
    filt_en = 1'b1;
    din = 8'h00;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (dout !== 8'hFF || rise_pls !== 8'h00 || fall_pls !== 8'h00) begin
        errors++;
        $display("FAIL filt_midcount edge %0d: dout=%h rise=%h fall=%h, want ff no pulses", e,
                 dout, rise_pls, fall_pls);
      end
    end
    filt_en = 1'b0;
    tick();
    checks++;
    if (dout !== 8'h00 || fall_pls !== 8'hFF || rise_pls !== 8'h00 || any_chg !== 1'b1) begin
      errors++;
      $display("FAIL filt_off_load: dout=%h rise=%h fall=%h any=%b, want 00/00/ff/1", dout,
               rise_pls, fall_pls, any_chg);
    end
    // re-enable: count must start from 0
    filt_en = 1'b1;
    din = 8'hFF;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (dout !== ((e >= 6) ? 8'hFF : 8'h00) || rise_pls !== ((e == 6) ? 8'hFF : 8'h00) ||
          fall_pls !== 8'h00) begin
        errors++;
        $display("FAIL filt_on_restart edge %0d: dout=%h rise=%h fall=%h", e, dout, rise_pls,
                 fall_pls);
      end
    end
  endtask

  task automatic test_async_reset();
    din = 8'h00;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dout !== 8'hA5 || rise_pls !== 8'h00 || fall_pls !== 8'h00 || any_chg !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: dout=%h rise=%h fall=%h any=%b, want a5 no pulses",
               dout, rise_pls, fall_pls, any_chg);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (dout !== ((e >= 6) ? 8'h00 : 8'hA5) || fall_pls !== ((e == 6) ? 8'hA5 : 8'h00) ||
          rise_pls !== 8'h00 || any_chg !== (e == 6)) begin
        errors++;
        $display("FAIL async_reset_restart edge %0d: dout=%h rise=%h fall=%h any=%b", e, dout,
                 rise_pls, fall_pls, any_chg);
      end
    end
  endtask

  task automatic test_param_sweep();
    int hold [8];
    for (int b = 0; b < 8; b++) hold[b] = $urandom_range(1, 10);
    filt_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (a_dout[n] !== exp_dout[n] || a_rise[n] !== exp_rise[n] ||
            a_fall[n] !== exp_fall[n] || a_any[n] !== exp_any[n]) begin
          errors++;
          $display("FAIL sweep inst %0d cyc %0d: dout=%h rise=%h fall=%h any=%b, want %h %h %h %b",
                   n, cyc, a_dout[n], a_rise[n], a_fall[n], a_any[n], exp_dout[n], exp_rise[n],
                   exp_fall[n], exp_any[n]);
        end
        checks++;
        if ((a_rise[n] & a_fall[n]) !== 8'h00 || a_any[n] !== (|(a_rise[n] | a_fall[n]))) begin
          errors++;
          $display("FAIL sweep_pulse_rules inst %0d cyc %0d: rise=%h fall=%h any=%b", n, cyc,
                   a_rise[n], a_fall[n], a_any[n]);
        end
      end
      for (int b = 0; b < 8; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          din[b]  = ~din[b];
          hold[b] = $urandom_range(1, 10);
        end
      end
      if ($urandom_range(0, 79) == 0) filt_en = ~filt_en;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    din     = 8'h00;
    filt_en = 1'b1;
    k       = 0;
    model_reset();
    test_reset();
    test_filtered_rise();
    test_glitch();
    test_bypass();
    test_async_reset();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itrx_aib_phy_bit_sync_filt.md
# itrx_aib_phy_bit_sync_filt

Multi-channel, parametrised synchroniser with optional per-channel glitch filter and edge-pulse outputs. It brings WIDTH asynchronous, quasi-static control/status bits into the clk domain through a NUM_FLOPS-deep flop chain. It then optionally requires FILT_CYCLES consecutive stable samples before updating each output. It sits at the AIB PHY boundary, where pad-level sideband signals (e.g. device-detect, power-on-reset, config strobes) enter core logic and need both debouncing and edge detection.

## Interface

- WIDTH, 8: number of independent channels, ≥1.
- NUM_FLOPS, 2: synchroniser depth per channel, ≥2.
- FILT_CYCLES, 4: consecutive stable synchronised samples required to update an output, ≥1.
- RST_VAL, {WIDTH{1'b0}}: per-channel reset value of the synchroniser chain and dout.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  asynchronous data inputs.
- filt_en  in  1  clk-domain filter enable; 0 = bypass filter.
- dout  out  WIDTH  synchronised, filtered outputs.
- rise_pls  out  WIDTH  one-cycle pulse when dout[i] goes 0→1.
- fall_pls  out  WIDTH  one-cycle pulse when dout[i] goes 1→0.
- any_chg  out  1  OR of rise_pls | fall_pls, registered with them.

## Operation

- Per channel i: the shift chain sync[i][NUM_FLOPS-1:0] samples din[i] into bit 0. s_i = sync[i][NUM_FLOPS-1].
- Filter counter cnt[i], width CW = $clog2(FILT_CYCLES+1).
- filt_en=1, each cycle:
  - s_i == dout[i]: cnt[i] ← 0.
  - s_i != dout[i] and cnt[i] == FILT_CYCLES-1: dout[i] ← s_i, cnt[i] ← 0.
  - Otherwise: cnt[i] ← cnt[i]+1.
- filt_en=0: dout[i] ← s_i every cycle, cnt[i] ← 0.
- A disagreement shorter than FILT_CYCLES cycles restarts the counter from 0 and leaves dout unchanged.
- The counter never exceeds FILT_CYCLES-1. No wrap-around is possible.
- rise_pls[i]/fall_pls[i] are registered and assert in the same cycle dout[i] takes its new value, for exactly one cycle.
- any_chg is registered and aligned with the pulses.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses; nothing is arbitrated.
- Multi-bit din is not coherent across channels. Skew of one cycle between channels is legal.

## Timing

- Reset values: sync chain = RST_VAL, dout = RST_VAL, cnt = 0, rise_pls = fall_pls = 0, any_chg = 0.
- No pulses are generated on reset deassertion, even if din ≠ RST_VAL. Reaching din through the normal path produces pulses then.
- Latency from the first clk edge sampling a new stable din[i]:
  - s_i: after NUM_FLOPS edges.
  - dout and pulses with filt_en=1: after NUM_FLOPS+FILT_CYCLES edges.
  - dout and pulses with filt_en=0: after NUM_FLOPS+1 edges.
- filt_en 1→0 mid-count: the next edge loads s_i, pulses if it differs, and clears cnt.
- filt_en 0→1: counting starts from 0 on the next edge.
- Reset mid-operation clears all state asynchronously. Outputs show reset values while rst_n=0.
- din must be held stable for ≥ NUM_FLOPS-1+FILT_CYCLES clk periods to be guaranteed to propagate when filtered.

## Structure

- Shared package itrx_aib_phy_pkg holds:
  - the CW computation function (clog2);
  - the default NUM_FLOPS/FILT_CYCLES constants used across the PHY sideband logic.
- Instantiate the existing single-bit synchroniser module, itrx_aib_phy_bit_sync, once per channel in a generate loop.
  - Extend it with a per-instance reset-value parameter so that RST_VAL applies to the chain.
- The filter, counter and edge logic form one natural sub-module, itrx_aib_phy_bit_filt, single channel, generated WIDTH times.
- any_chg is the top-level OR reduction of the registered pulse outputs.

## Test plan

- Reset:
  - WIDTH=8, RST_VAL=8'hA5, din=8'h00 held through rst_n release.
  - Required: dout=8'hA5, no pulses during reset.
  - After 2+4 edges: dout=8'h00, fall_pls=8'hA5 for one cycle, any_chg=1 for one cycle.
- Filtered rise: filt_en=1, din[0] 0→1 held.
  - Required: dout[0]=1 and rise_pls[0]=1 exactly 6 edges later, one cycle wide.
- Glitch rejection: filt_en=1, din[3] high for 4 cycles (s pulse of 4 < needs ≥ FILT_CYCLES after chain), then low.
  - Sweep glitch width 1..3 synchronised cycles → dout[3] stays 0, no pulses.
  - Width 4 → one rise_pls, then a fall_pls 4 cycles after the return.
- Bypass: filt_en=0, din=8'hFF.
  - Required: dout=8'hFF after 3 edges, rise_pls=8'hFF for one cycle.
  - Toggle filt_en to 1 mid-count and check that the counter restarts.
- Async reset mid-count: assert rst_n low between clock edges during a filter count.
  - Required: outputs return to RST_VAL immediately.
  - After release, the count restarts from 0 and no spurious pulses occur.
- Parameter sweep: NUM_FLOPS∈{2,3,4}, FILT_CYCLES∈{1,2,7}, WIDTH∈{1,8}.
  - Random din with hold times straddling the threshold.
  - Scoreboard checks latency, pulse width, the rise/fall exclusivity per channel, and any_chg equality with the OR of the pulses.
